regfile_write_arbiter: RTL

- Shares the single register-file write port between NUM_REQ requesters (writeback, multiply/divide unit, exception/status logic, I/O).
- Each cycle, picks at most one requester by round-robin, acknowledges it, and presents a registered write (enable, register index, data) to the register file one cycle later.
- Write data is forced to zero whenever the write enable is low, so the downstream decoder sees no stray data.
- Also keeps a saturating count of contention cycles for performance debug.

---
 rtl/regfile_write_arbiter.sv | 89 ++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// One requester is granted per cycle; the granted write is registered
// and presented to the register file on the following cycle. Writes to
// register 0 are acknowledged but never strobed. A saturating counter
// records cycles in which two or more requesters competed.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clock,
  input  logic                           ctrl_reset,
  input  logic                           stall,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
  output logic [DATA_WIDTH-1:0]          data_writeReg,
  output logic [CNT_WIDTH-1:0]           contention_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  contended;
  logic                  addr_nonzero;

  // Scan from rr_ptr upward (wrapping) and grant the first valid requester.
  always_comb begin
    logic [PTR_W:0] sum;
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    if (!ctrl_reset && !stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (sum >= NUM_REQ_EXT) sum = sum - NUM_REQ_EXT;
        if (!grant_any && req_valid[sum[PTR_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = sum[PTR_W-1:0];
        end
      end
      if (grant_any) req_ready[grant_idx] = 1'b1;
    end
  end

  // Select the granted requester's index/data and classify the cycle.
  always_comb begin
    grant_addr   = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    grant_data   = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    addr_nonzero = (grant_addr != '0);
    contended    = !stall && ($countones(req_valid) >= 2);
  end

  // Pointer advance, registered write stage and contention counter.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      rr_ptr           <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      contention_cnt   <= '0;
    end else begin
      if (grant_any) begin
        rr_ptr           <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        ctrl_writeReg    <= grant_addr;
        ctrl_writeEnable <= addr_nonzero;
        data_writeReg    <= addr_nonzero ? grant_data : '0;
      end else begin
        ctrl_writeEnable <= 1'b0;
        data_writeReg    <= '0;
      end
      if (contended && (contention_cnt != '1)) begin
        contention_cnt <= contention_cnt + 1'b1;
      end
    end
  end

endmodule
